// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and constants for the front-end sequencing controller.
//   state_e    : controller FSM states (RUN, VBUSY, HALT)
//   OP_CTRL    : op field of control-class instructions
//   INST_HALT  : inst field of HALT within the control class
//   NOP_OP/NOP_INST : encoding loaded into the fetch register on a flush
//   VCNT_W     : width of the vector-unit occupancy counter
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        VBUSY = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [1:0] OP_CTRL   = 2'b11;
    localparam logic [1:0] INST_HALT = 2'b11;
    localparam logic [1:0] NOP_OP    = 2'b00;
    localparam logic [1:0] NOP_INST  = 2'b01;

    localparam int VCNT_W = 4;

    function automatic logic is_halt(input logic [1:0] op, input logic [1:0] inst);
        return (op == OP_CTRL) && (inst == INST_HALT);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational hazard detection for the decode-stage instruction.
//   ex_is_load, ex_rd     : scalar load currently in execute and its destination
//   id_flagV, id_r2, id_r3: decode-stage vector flag and source registers
//   vcnt                  : remaining occupancy of the vector unit (0 = free)
//   lu_stall              : decode reads a register still being loaded
//   v_stall               : decode holds a vector op while the vector unit is busy
module hazard_detect (
    input  logic       ex_is_load,
    input  logic [3:0] ex_rd,
    input  logic       id_flagV,
    input  logic [3:0] id_r2,
    input  logic [3:0] id_r3,
    input  logic [3:0] vcnt,
    output logic       lu_stall,
    output logic       v_stall
);

    // Vector instructions read the vector register file, so the scalar
    // load-use check only applies to scalar decode instructions.
    assign lu_stall = ex_is_load && !id_flagV && ((ex_rd == id_r2) || (ex_rd == id_r3));
    assign v_stall  = id_flagV && (vcnt != 4'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Program counter and fetch/decode sequencing for the front end.
//   clk, rst   : clock, synchronous active-high reset
//   jmp_en, jmp_target : taken jump resolved in execute and its destination
//   id_*       : decode-stage instruction fields used for hazard/HALT decisions
//   ex_is_load, ex_rd  : execute-stage load information for load-use detection
//   pc         : registered fetch address
//   if_flush   : load NOP into the fetch register at the next edge
//   if_hold    : fetch register keeps its value at the next edge
//   id_bubble  : insert NOP into ID/EX at the next edge
//   vec_issue  : decode vector instruction advances to execute this cycle
//   halted     : registered HALT indication
// Handshake note: the control outputs are combinational requests that take
// effect at the next rising edge; there is no backpressure from the pipeline.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              PC_STEP  = 4,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              VEC_LAT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_target,
    input  logic [1:0]      id_op,
    input  logic [1:0]      id_inst,
    input  logic            id_flagV,
    input  logic [3:0]      id_r2,
    input  logic [3:0]      id_r3,
    input  logic            ex_is_load,
    input  logic [3:0]      ex_rd,
    output logic [PC_W-1:0] pc,
    output logic            if_flush,
    output logic            if_hold,
    output logic            id_bubble,
    output logic            vec_issue,
    output logic            halted
);

    localparam logic [VCNT_W-1:0] VCNT_INIT = VCNT_W'(VEC_LAT - 1);
    localparam logic [PC_W-1:0]   PC_INC    = PC_W'(PC_STEP);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              halted_q, halted_d;

    logic lu_stall;
    logic v_stall;
    logic enter_halt;

    hazard_detect u_hazard_detect (
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_flagV   (id_flagV),
        .id_r2      (id_r2),
        .id_r3      (id_r3),
        .vcnt       (vcnt_q),
        .lu_stall   (lu_stall),
        .v_stall    (v_stall)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        vcnt_d     = vcnt_q;
        halted_d   = halted_q;
        enter_halt = 1'b0;
        if_flush   = 1'b0;
        if_hold    = 1'b0;
        id_bubble  = 1'b0;
        vec_issue  = 1'b0;

        // The vector unit drains on its own: jumps, stalls and HALT do not
        // cancel an operation that has already been issued.
        if (vcnt_q != '0) begin
            vcnt_d = vcnt_q - 1'b1;
        end

        if (rst) begin
            if_flush = 1'b1;
        end else if (state_q == HALT) begin
            if_hold   = 1'b1;
            id_bubble = 1'b1;
        end else begin
            if (jmp_en) begin
                pc_d      = jmp_target;
                if_flush  = 1'b1;
                id_bubble = 1'b1;
            end else if (lu_stall || v_stall) begin
                if_hold   = 1'b1;
                id_bubble = 1'b1;
            end else begin
                pc_d = pc_q + PC_INC;
                if (id_flagV) begin
                    vec_issue = 1'b1;
                    vcnt_d    = VCNT_INIT;
                end
                enter_halt = is_halt(id_op, id_inst);
            end

            if (enter_halt) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end else begin
                state_d = (vcnt_d != '0) ? VBUSY : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= PC_RESET;
            vcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vcnt_q   <= vcnt_d;
            halted_q <= halted_d;
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic checked every cycle against a time-based behavioural model.
module tb_fetch_ctrl;

    localparam int              PC_W     = 32;
    localparam int              PC_STEP  = 4;
    localparam logic [PC_W-1:0] PC_RESET = '0;
    localparam int              VEC_LAT  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            jmp_en;
    logic [PC_W-1:0] jmp_target;
    logic [1:0]      id_op;
    logic [1:0]      id_inst;
    logic            id_flagV;
    logic [3:0]      id_r2;
    logic [3:0]      id_r3;
    logic            ex_is_load;
    logic [3:0]      ex_rd;
    logic [PC_W-1:0] pc;
    logic            if_flush;
    logic            if_hold;
    logic            id_bubble;
    logic            vec_issue;
    logic            halted;

    fetch_ctrl #(
        .PC_W     (PC_W),
        .PC_STEP  (PC_STEP),
        .PC_RESET (PC_RESET),
        .VEC_LAT  (VEC_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jmp_en     (jmp_en),
        .jmp_target (jmp_target),
        .id_op      (id_op),
        .id_inst    (id_inst),
        .id_flagV   (id_flagV),
        .id_r2      (id_r2),
        .id_r3      (id_r3),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .pc         (pc),
        .if_flush   (if_flush),
        .if_hold    (if_hold),
        .id_bubble  (id_bubble),
        .vec_issue  (vec_issue),
        .halted     (halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // The vector unit is modelled as "free from cycle vfree onward"; cyc
    // counts rising edges since the bench started.
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] m_pc;
    bit              m_halted = 1'b0;
    int              cyc = 0;
    int              vfree = 0;
    bit              e_flush, e_hold, e_bubble, e_issue, e_lu, e_vs;

    always begin
        @(negedge clk);
        #2;
        e_flush = 0; e_hold = 0; e_bubble = 0; e_issue = 0;
        e_lu = ex_is_load && !id_flagV && (ex_rd == id_r2 || ex_rd == id_r3);
        e_vs = id_flagV && (cyc < vfree);
        if (rst) begin
            e_flush = 1;
        end else if (m_halted) begin
            e_hold = 1; e_bubble = 1;
        end else if (jmp_en) begin
            e_flush = 1; e_bubble = 1;
        end else if (e_lu || e_vs) begin
            e_hold = 1; e_bubble = 1;
        end else begin
            e_issue = id_flagV;
        end
        chk("model_if_flush", if_flush, e_flush);
        chk("model_if_hold", if_hold, e_hold);
        chk("model_id_bubble", id_bubble, e_bubble);
        chk("model_vec_issue", vec_issue, e_issue);
        chk("model_halted", halted, m_halted);
        if (exp_q.size() != 0) chk("model_pc", pc, exp_q.pop_front());

        @(posedge clk);
        if (rst) begin
            m_pc = PC_RESET; m_halted = 0; vfree = 0;
        end else if (m_halted) begin
            // frozen
        end else if (jmp_en) begin
            m_pc = jmp_target;
        end else if (e_lu || e_vs) begin
            // hold
        end else begin
            m_pc = m_pc + PC_STEP;
            if (id_flagV) vfree = cyc + VEC_LAT;
            if (id_op == 2'b11 && id_inst == 2'b11) m_halted = 1;
        end
        cyc++;
        exp_q.push_back(m_pc);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        jmp_en = 0; jmp_target = '0;
        id_op = 2'b00; id_inst = 2'b01; id_flagV = 0;
        id_r2 = 4'd0; id_r3 = 4'd0;
        ex_is_load = 0; ex_rd = 4'd15;
    endtask

    task automatic wait_vec_issue(input string name, input int exp_stalls);
        int n = 0;
        int got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            #1;
            if (vec_issue) got = 1;
            else begin
                if (if_hold) n++;
                @(negedge clk);
            end
        end
        chk({name, "_stalls"}, n, exp_stalls);
        chk({name, "_issued"}, got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    logic [PC_W-1:0] h;

    initial begin
        rst = 1;
        clear_inputs();
        @(negedge clk);
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_ctl", {if_flush, if_hold, id_bubble, vec_issue, halted}, 5'b10000);

        // free run
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("free_pc", pc, i * 4);
            chk("free_ctl", {if_flush, if_hold, id_bubble, vec_issue}, 4'b0000);
            @(negedge clk);
        end

        // jump from 0x10 to 0x40
        jmp_en = 1; jmp_target = 32'h40;
        #1;
        chk("jmp_pc_before", pc, 32'h10);
        chk("jmp_ctl", {if_flush, if_hold, id_bubble}, 3'b101);
        @(negedge clk);
        jmp_en = 0;
        #1;
        chk("jmp_pc_after", pc, 32'h40);

        // load-use hit on r3
        @(negedge clk);
        ex_is_load = 1; ex_rd = 4'd5; id_r3 = 4'd5; id_r2 = 4'd0;
        #1;
        chk("lu_ctl", {if_hold, id_bubble, if_flush}, 3'b110);
        @(negedge clk);
        ex_is_load = 0;
        #1;
        chk("lu_pc_held", pc, 32'h44);
        chk("lu_released", if_hold, 0);
        @(negedge clk);
        #1;
        chk("lu_pc_adv", pc, 32'h48);

        // load to a different register: no stall
        ex_is_load = 1; ex_rd = 4'd6;
        #1;
        chk("lu_miss_hold", if_hold, 0);
        @(negedge clk);
        ex_is_load = 0;
        #1;
        chk("lu_miss_pc", pc, 32'h4c);

        // back-to-back vector instructions
        id_flagV = 1;
        #1;
        chk("vec_first_issue", vec_issue, 1);
        @(negedge clk);
        wait_vec_issue("vec_b2b", VEC_LAT - 1);
        @(negedge clk);
        id_flagV = 0;
        #1;
        chk("vec_scalar_between", if_hold, 0);
        @(negedge clk);
        id_flagV = 1;
        wait_vec_issue("vec_gap2", VEC_LAT - 2);
        @(negedge clk);
        id_flagV = 0;
        repeat (4) @(negedge clk);

        // HALT entry, jump ignored, reset exit
        id_op = 2'b11; id_inst = 2'b11;
        #1;
        h = pc;
        chk("halt_entry_ctl", {if_flush, if_hold, id_bubble, halted}, 4'b0000);
        @(negedge clk);
        id_op = 2'b00; id_inst = 2'b01;
        #1;
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc, h + PC_STEP);
        chk("halt_ctl", {if_hold, id_bubble}, 2'b11);
        @(negedge clk);
        jmp_en = 1; jmp_target = 32'h100;
        #1;
        chk("halt_jmp_flush", if_flush, 0);
        @(negedge clk);
        jmp_en = 0;
        #1;
        chk("halt_jmp_ignored_pc", pc, h + PC_STEP);
        @(negedge clk);
        rst = 1;
        #1;
        chk("halt_rst_ctl", {if_flush, if_hold, id_bubble}, 3'b100);
        @(negedge clk);
        rst = 0;
        #1;
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_flag", halted, 0);

        // HALT squashed by a simultaneous jump
        id_op = 2'b11; id_inst = 2'b11; jmp_en = 1; jmp_target = 32'h80;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("halt_jmp_no_halt", halted, 0);
        chk("halt_jmp_pc", pc, 32'h80);

        // randomized traffic
        repeat (3000) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 199) == 0) || (halted && $urandom_range(0, 9) == 0);
            jmp_en     = ($urandom_range(0, 7) == 0);
            jmp_target = $urandom();
            id_flagV   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) begin
                id_op = 2'b11; id_inst = 2'b11;
            end else begin
                id_op = 2'($urandom_range(0, 3)); id_inst = 2'($urandom_range(0, 2));
            end
            id_r2      = 4'($urandom_range(0, 3));
            id_r3      = 4'($urandom_range(0, 3));
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 4'($urandom_range(0, 5));
        end

        @(negedge clk);
        clear_inputs();
        rst = 0;
        repeat (3) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
